// File: rtl/lcd_timing_gen_if.sv
// Output bundle of the LCD raster timing generator.
//   master : driven by lcd_timing_gen
//   slave  : consumed by the pixel/pattern stage and the panel pins
// Signals:
//   hcount_reg[9:0], Vcount_reg[8:0] : active-region pixel coordinates
//   flagh, flagv                     : active-region flags
//   rgb_en                           : pixel-stage output register enable
//   lcd_hsync, lcd_vsync, lcd_de     : panel pins, aligned to the pixel pipeline
//   frame_start                      : pulse at position (0,0)
//   lcd_disp                         : panel display enable (LCD_PWRSEQ_EN builds only)
interface lcd_timing_gen_if;
`ifdef LCD_PWRSEQ_EN
    logic       lcd_disp;
`endif
    logic [9:0] hcount_reg;
    logic [8:0] Vcount_reg;
    logic       flagh;
    logic       flagv;
    logic       rgb_en;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       lcd_de;
    logic       frame_start;

    modport master (
`ifdef LCD_PWRSEQ_EN
        output lcd_disp,
`endif
        output hcount_reg, Vcount_reg, flagh, flagv, rgb_en,
        output lcd_hsync, lcd_vsync, lcd_de, frame_start
    );

    modport slave (
`ifdef LCD_PWRSEQ_EN
        input lcd_disp,
`endif
        input hcount_reg, Vcount_reg, flagh, flagv, rgb_en,
        input lcd_hsync, lcd_vsync, lcd_de, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a 480x272 RGB LCD panel, clocked by the pixel clock.
// Ports:
//   clk_lcd : pixel clock, rising edge
//   rst     : asynchronous active-high reset
//   lcd     : lcd_timing_gen_if.master output bundle (coordinates, flags, pins)
// Optional feature macro: LCD_PWRSEQ_EN
//   defined   -> first 4 frames after reset are blanked, lcd_disp rises at frame 2
//   undefined -> no blanking, no lcd_disp
module lcd_timing_gen #(
    parameter int unsigned H_SYNC = 41,
    parameter int unsigned H_BP   = 2,
    parameter int unsigned H_ACT  = 480,
    parameter int unsigned H_FP   = 2,
    parameter int unsigned V_SYNC = 10,
    parameter int unsigned V_BP   = 2,
    parameter int unsigned V_ACT  = 272,
    parameter int unsigned V_FP   = 2
) (
    input  logic             clk_lcd,
    input  logic             rst,
    lcd_timing_gen_if.master lcd
);
    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("lcd_timing_gen: H_TOTAL does not fit a 10-bit counter");
    end
    if (V_TOTAL > 512) begin : g_v_total_chk
        $error("lcd_timing_gen: V_TOTAL does not fit a 9-bit counter");
    end

    typedef enum logic [1:0] {
        RGN_SYNC,
        RGN_BACK,
        RGN_ACTIVE,
        RGN_FRONT
    } region_e;

    // Region of a raw position; zero-width porches simply never match.
    function automatic region_e region_of(input int unsigned pos,
                                          input int unsigned sync_w,
                                          input int unsigned bp_w,
                                          input int unsigned act_w);
        if (pos < sync_w)                       return RGN_SYNC;
        else if (pos < sync_w + bp_w)           return RGN_BACK;
        else if (pos < sync_w + bp_w + act_w)   return RGN_ACTIVE;
        else                                    return RGN_FRONT;
    endfunction

    logic       run_q;
    logic [9:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    region_e    hstate_q, hstate_d;
    region_e    vstate_q, vstate_d;
    logic       act_h_d, act_v_d, frame_start_d;

    logic       flagh_q, flagv_q;
    logic [9:0] hcount_q;
    logic [8:0] vcount_q;
    logic       frame_start_q;
    logic       rgb_en_q, lcd_de_q;
    logic       hsync_p_q, vsync_p_q;
    logic       lcd_hsync_q, lcd_vsync_q;

`ifdef LCD_PWRSEQ_EN
    localparam int unsigned FRAME_CNT_W = 3;
    localparam logic [FRAME_CNT_W-1:0] UNBLANK_FRAME = FRAME_CNT_W'(5);
    localparam logic [FRAME_CNT_W-1:0] DISP_FRAME    = FRAME_CNT_W'(2);

    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   blank_d;
    logic                   lcd_disp_q;

    // Counts frame starts since reset, saturating once the panel is unblanked.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d && (frame_cnt_q != UNBLANK_FRAME)) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
        blank_d = frame_cnt_d < UNBLANK_FRAME;
    end

    always_ff @(posedge clk_lcd or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            lcd_disp_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            lcd_disp_q  <= frame_cnt_d >= DISP_FRAME;
        end
    end

    assign lcd.lcd_disp = lcd_disp_q;
`endif

    // Next raster position; the first edge after reset loads (0,0) rather than advancing.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (run_q) begin
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 9'(V_TOTAL - 1)) ? 9'd0 : v_q + 9'd1;
            end else begin
                h_d = h_q + 10'd1;
                v_d = v_q;
            end
        end
        hstate_d      = region_of(32'(h_d), H_SYNC, H_BP, H_ACT);
        vstate_d      = region_of(32'(v_d), V_SYNC, V_BP, V_ACT);
        frame_start_d = (h_d == 10'd0) && (v_d == 9'd0);
`ifdef LCD_PWRSEQ_EN
        act_h_d = (hstate_d == RGN_ACTIVE) && !blank_d;
        act_v_d = (vstate_d == RGN_ACTIVE) && !blank_d;
`else
        act_h_d = hstate_d == RGN_ACTIVE;
        act_v_d = vstate_d == RGN_ACTIVE;
`endif
    end

    // Region state, coordinate outputs and the 1/2-clock pin delay pipes.
    always_ff @(posedge clk_lcd or posedge rst) begin
        if (rst) begin
            run_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            // Parked outside SYNC so the undelayed syncs read inactive until the first edge.
            hstate_q      <= RGN_FRONT;
            vstate_q      <= RGN_FRONT;
            flagh_q       <= 1'b0;
            flagv_q       <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            rgb_en_q      <= 1'b0;
            lcd_de_q      <= 1'b0;
            hsync_p_q     <= 1'b1;
            vsync_p_q     <= 1'b1;
            lcd_hsync_q   <= 1'b1;
            lcd_vsync_q   <= 1'b1;
        end else begin
            run_q         <= 1'b1;
            h_q           <= h_d;
            v_q           <= v_d;
            hstate_q      <= hstate_d;
            vstate_q      <= vstate_d;
            flagh_q       <= act_h_d;
            flagv_q       <= act_v_d;
            hcount_q      <= act_h_d ? h_d - 10'(H_ACT_START) : 10'd0;
            vcount_q      <= act_v_d ? v_d - 9'(V_ACT_START) : 9'd0;
            frame_start_q <= frame_start_d;
            rgb_en_q      <= flagh_q & flagv_q;
            lcd_de_q      <= rgb_en_q;
            hsync_p_q     <= hstate_q != RGN_SYNC;
            vsync_p_q     <= vstate_q != RGN_SYNC;
            lcd_hsync_q   <= hsync_p_q;
            lcd_vsync_q   <= vsync_p_q;
        end
    end

    assign lcd.hcount_reg  = hcount_q;
    assign lcd.Vcount_reg  = vcount_q;
    assign lcd.flagh       = flagh_q;
    assign lcd.flagv       = flagv_q;
    assign lcd.rgb_en      = rgb_en_q;
    assign lcd.lcd_de      = lcd_de_q;
    assign lcd.lcd_hsync   = lcd_hsync_q;
    assign lcd.lcd_vsync   = lcd_vsync_q;
    assign lcd.frame_start = frame_start_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: a default 480x272 instance and a small
// instance (with zero-width porches) share clock and reset; every cycle both are
// compared against an arithmetic raster model indexed by clocks since reset release.
module tb_lcd_timing_gen;
    typedef struct packed {
        logic [9:0] hcount;
        logic [8:0] vcount;
        logic       flagh;
        logic       flagv;
        logic       rgb_en;
        logic       lcd_hsync;
        logic       lcd_vsync;
        logic       lcd_de;
        logic       frame_start;
        logic       lcd_disp;
    } out_t;

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf;
    } geom_t;

    logic  clk;
    logic  rst;
    geom_t g_full;
    geom_t g_small;
    int    t;
    int    vectors;
    int    miscompares;
    out_t  obs_full;
    out_t  obs_small;

    lcd_timing_gen_if if_full ();
    lcd_timing_gen_if if_small ();

    lcd_timing_gen u_full (
        .clk_lcd (clk),
        .rst     (rst),
        .lcd     (if_full)
    );

    lcd_timing_gen #(
        .H_SYNC(3), .H_BP(2), .H_ACT(8), .H_FP(0),
        .V_SYNC(2), .V_BP(0), .V_ACT(5), .V_FP(1)
    ) u_small (
        .clk_lcd (clk),
        .rst     (rst),
        .lcd     (if_small)
    );

`ifdef LCD_PWRSEQ_EN
    assign obs_full  = {if_full.hcount_reg, if_full.Vcount_reg, if_full.flagh, if_full.flagv,
                        if_full.rgb_en, if_full.lcd_hsync, if_full.lcd_vsync, if_full.lcd_de,
                        if_full.frame_start, if_full.lcd_disp};
    assign obs_small = {if_small.hcount_reg, if_small.Vcount_reg, if_small.flagh, if_small.flagv,
                        if_small.rgb_en, if_small.lcd_hsync, if_small.lcd_vsync, if_small.lcd_de,
                        if_small.frame_start, if_small.lcd_disp};
`else
    assign obs_full  = {if_full.hcount_reg, if_full.Vcount_reg, if_full.flagh, if_full.flagv,
                        if_full.rgb_en, if_full.lcd_hsync, if_full.lcd_vsync, if_full.lcd_de,
                        if_full.frame_start, 1'b0};
    assign obs_small = {if_small.hcount_reg, if_small.Vcount_reg, if_small.flagh, if_small.flagv,
                        if_small.rgb_en, if_small.lcd_hsync, if_small.lcd_vsync, if_small.lcd_de,
                        if_small.frame_start, 1'b0};
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog t=%0d: run did not finish in time", t);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int htot(geom_t g); return g.hs + g.hb + g.ha + g.hf; endfunction
    function automatic int vtot(geom_t g); return g.vs + g.vb + g.va + g.vf; endfunction
    function automatic int ftot(geom_t g); return htot(g) * vtot(g); endfunction
    function automatic int hpos(geom_t g, int tt); return tt % htot(g); endfunction
    function automatic int vpos(geom_t g, int tt); return (tt / htot(g)) % vtot(g); endfunction

    function automatic bit blanked(geom_t g, int tt);
`ifdef LCD_PWRSEQ_EN
        return (tt / ftot(g)) < 4;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit hact(geom_t g, int tt);
        if (tt < 0) return 1'b0;
        return hpos(g, tt) >= g.hs + g.hb && hpos(g, tt) < g.hs + g.hb + g.ha && !blanked(g, tt);
    endfunction

    function automatic bit vact(geom_t g, int tt);
        if (tt < 0) return 1'b0;
        return vpos(g, tt) >= g.vs + g.vb && vpos(g, tt) < g.vs + g.vb + g.va && !blanked(g, tt);
    endfunction

    function automatic bit hsync_n(geom_t g, int tt);
        return tt < 0 || hpos(g, tt) >= g.hs;
    endfunction

    function automatic bit vsync_n(geom_t g, int tt);
        return tt < 0 || vpos(g, tt) >= g.vs;
    endfunction

    // Expected outputs tt clocks after reset release (tt < 0: in reset).
    function automatic out_t expect_at(geom_t g, int tt);
        out_t o;
        o.flagh       = hact(g, tt);
        o.flagv       = vact(g, tt);
        o.hcount      = o.flagh ? 10'(hpos(g, tt) - g.hs - g.hb) : 10'd0;
        o.vcount      = o.flagv ? 9'(vpos(g, tt) - g.vs - g.vb) : 9'd0;
        o.rgb_en      = hact(g, tt - 1) && vact(g, tt - 1);
        o.lcd_de      = hact(g, tt - 2) && vact(g, tt - 2);
        o.lcd_hsync   = hsync_n(g, tt - 2);
        o.lcd_vsync   = vsync_n(g, tt - 2);
        o.frame_start = tt >= 0 && (tt % ftot(g)) == 0;
`ifdef LCD_PWRSEQ_EN
        o.lcd_disp    = tt >= 0 && (tt / ftot(g)) >= 1;
`else
        o.lcd_disp    = 1'b0;
`endif
        return o;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        out_t ef, es;
        rst = 1'b1;
        t   = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ef = expect_at(g_full, t);
            es = expect_at(g_small, t);
            vectors += 2;
            if (obs_full !== ef) begin
                miscompares++;
                $display("FAIL reset_full cyc=%0d got=%h exp=%h", i, obs_full, ef);
            end
            if (obs_small !== es) begin
                miscompares++;
                $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, obs_small, es);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_startup(input int ncyc);
        out_t ef, es;
        int   hs_first = -1, hs_low = 0, fh_first = -1, fh_cnt = 0;
        int   exp_fh_first, exp_fh_cnt;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            t++;
            ef = expect_at(g_full, t);
            es = expect_at(g_small, t);
            vectors += 2;
            if (obs_full !== ef) begin
                miscompares++;
                $display("FAIL startup_full t=%0d got=%h exp=%h", t, obs_full, ef);
            end
            if (obs_small !== es) begin
                miscompares++;
                $display("FAIL startup_small t=%0d got=%h exp=%h", t, obs_small, es);
            end
            if (t < 525) begin
                if (obs_full.lcd_hsync === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = t;
                end
                if (obs_full.flagh === 1'b1) begin
                    fh_cnt++;
                    if (fh_first < 0) fh_first = t;
                end
            end
        end
`ifdef LCD_PWRSEQ_EN
        exp_fh_first = -1;
        exp_fh_cnt   = 0;
`else
        exp_fh_first = 43;
        exp_fh_cnt   = 480;
`endif
        vectors += 4;
        if (hs_first !== 2) begin
            miscompares++;
            $display("FAIL hsync_first_low got=%0d exp=2", hs_first);
        end
        if (hs_low !== 41) begin
            miscompares++;
            $display("FAIL hsync_width got=%0d exp=41", hs_low);
        end
        if (fh_first !== exp_fh_first) begin
            miscompares++;
            $display("FAIL flagh_first got=%0d exp=%0d", fh_first, exp_fh_first);
        end
        if (fh_cnt !== exp_fh_cnt) begin
            miscompares++;
            $display("FAIL flagh_per_line got=%0d exp=%0d", fh_cnt, exp_fh_cnt);
        end
    endtask

    task automatic test_frame_small(input int nframes);
        out_t es;
        int   last_fs = -1, de_cnt = 0, exp_de;
        for (int i = 0; i < nframes * ftot(g_small); i++) begin
            @(negedge clk);
            t++;
            es = expect_at(g_small, t);
            vectors++;
            if (obs_small !== es) begin
                miscompares++;
                $display("FAIL frame_small t=%0d got=%h exp=%h", t, obs_small, es);
            end
            if (obs_small.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    exp_de = blanked(g_small, last_fs) ? 0 : g_small.ha * g_small.va;
                    vectors += 2;
                    if (t - last_fs !== ftot(g_small)) begin
                        miscompares++;
                        $display("FAIL frame_period got=%0d exp=%0d", t - last_fs, ftot(g_small));
                    end
                    if (de_cnt !== exp_de) begin
                        miscompares++;
                        $display("FAIL active_per_frame got=%0d exp=%0d", de_cnt, exp_de);
                    end
                end
                last_fs = t;
                de_cnt  = 0;
            end
            if (obs_small.flagh === 1'b1 && obs_small.flagv === 1'b1) de_cnt++;
        end
    endtask

    task automatic test_mid_reset(input int iters);
        out_t ef, es;
        int   f, target, hold, run;
        f = ftot(g_small);
        for (int k = 0; k < iters; k++) begin
            target = t - (t % f) + f
                   + (g_small.vs + g_small.vb + $urandom_range(g_small.va - 1, 0)) * htot(g_small)
                   + g_small.hs + g_small.hb + $urandom_range(g_small.ha - 1, 0);
            while (t < target) begin
                @(negedge clk);
                t++;
                ef = expect_at(g_full, t);
                es = expect_at(g_small, t);
                vectors += 2;
                if (obs_full !== ef) begin
                    miscompares++;
                    $display("FAIL pre_reset_full t=%0d got=%h exp=%h", t, obs_full, ef);
                end
                if (obs_small !== es) begin
                    miscompares++;
                    $display("FAIL pre_reset_small t=%0d got=%h exp=%h", t, obs_small, es);
                end
            end
            // Asynchronous assertion between clock edges.
            #2 rst = 1'b1;
            t = -1;
            #1;
            ef = expect_at(g_full, t);
            es = expect_at(g_small, t);
            vectors += 2;
            if (obs_full !== ef) begin
                miscompares++;
                $display("FAIL async_reset_full got=%h exp=%h", obs_full, ef);
            end
            if (obs_small !== es) begin
                miscompares++;
                $display("FAIL async_reset_small got=%h exp=%h", obs_small, es);
            end
            hold = $urandom_range(4, 1);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                es = expect_at(g_small, t);
                vectors++;
                if (obs_small !== es) begin
                    miscompares++;
                    $display("FAIL reset_hold_small got=%h exp=%h", obs_small, es);
                end
            end
            rst = 1'b0;
            run = $urandom_range(3 * f, f);
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                t++;
                ef = expect_at(g_full, t);
                es = expect_at(g_small, t);
                vectors += 2;
                if (obs_full !== ef) begin
                    miscompares++;
                    $display("FAIL restart_full t=%0d got=%h exp=%h", t, obs_full, ef);
                end
                if (obs_small !== es) begin
                    miscompares++;
                    $display("FAIL restart_small t=%0d got=%h exp=%h", t, obs_small, es);
                end
            end
        end
    endtask

    initial begin
        g_full      = '{hs: 41, hb: 2, ha: 480, hf: 2, vs: 10, vb: 2, va: 272, vf: 2};
        g_small     = '{hs: 3, hb: 2, ha: 8, hf: 0, vs: 2, vb: 0, va: 5, vf: 1};
        vectors     = 0;
        miscompares = 0;
        t           = -1;
        rst         = 1'b1;
        test_reset();
        test_startup(1200);
        test_frame_small(7);
        test_mid_reset(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
